// File: rtl/uart_rx_core_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_core_pkg
// Shared definitions for the UART receive front end:
//   - rx_state_e     : receiver FSM states
//   - PRESCALE_*     : legal oversampling ratios and the fallback ratio
//   - CMD_*          : command bytes understood by the system controller
//   - legal_prescale : maps any PRESCALE input onto a supported ratio
// ----------------------------------------------------------------------------
package uart_rx_core_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        CHECK
    } rx_state_e;

    localparam int unsigned PRESCALE_8       = 8;
    localparam int unsigned PRESCALE_16      = 16;
    localparam int unsigned PRESCALE_32      = 32;
    localparam int unsigned PRESCALE_DEFAULT = PRESCALE_8;

    localparam logic [7:0] CMD_AA = 8'hAA;
    localparam logic [7:0] CMD_BB = 8'hBB;
    localparam logic [7:0] CMD_CC = 8'hCC;
    localparam logic [7:0] CMD_DD = 8'hDD;

    // Unsupported ratios fall back to the default so a frame is still timed sanely.
    function automatic int unsigned legal_prescale(input int unsigned p);
        if (p == PRESCALE_8 || p == PRESCALE_16 || p == PRESCALE_32) begin
            return p;
        end
        return PRESCALE_DEFAULT;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// ----------------------------------------------------------------------------
// uart_rx_sampler
// Per-bit oversampling timebase for the UART receiver. Counts edge_cnt over
// 0..prescale-1, captures the line at prescale/2-1, prescale/2, prescale/2+1
// and presents the 2-of-3 majority.
// Ports:
//   CLK, RST     clock, asynchronous active-low reset
//   enable       count while the receiver is inside a frame; held at 0 otherwise
//   rx           serial line (already synchronised if required)
//   prescale     latched oversampling ratio for the current frame
//   edge_cnt     current position inside the bit
//   sampled_bit  majority vote of the three captures
//   sample_done  one-cycle pulse: sampled_bit is valid (edge_cnt = prescale/2+2)
//   bit_done     one-cycle pulse: last cycle of the bit (edge_cnt = prescale-1)
// ----------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  enable,
    input  logic                  rx,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  sampled_bit,
    output logic                  sample_done,
    output logic                  bit_done
);

    logic [PRESCALE_W-1:0] edge_cnt_q;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] last;
    logic [2:0]            samples_q;

    assign half = prescale >> 1;
    assign last = prescale - PRESCALE_W'(1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_q <= '0;
            samples_q  <= '0;
        end else if (!enable) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= (edge_cnt_q == last) ? '0 : edge_cnt_q + PRESCALE_W'(1);
            if (edge_cnt_q == half - PRESCALE_W'(1)) samples_q[0] <= rx;
            if (edge_cnt_q == half)                  samples_q[1] <= rx;
            if (edge_cnt_q == half + PRESCALE_W'(1)) samples_q[2] <= rx;
        end
    end

    assign edge_cnt    = edge_cnt_q;
    assign sampled_bit = (samples_q[0] & samples_q[1]) |
                         (samples_q[0] & samples_q[2]) |
                         (samples_q[1] & samples_q[2]);
    assign sample_done = enable && (edge_cnt_q == half + PRESCALE_W'(2));
    assign bit_done    = enable && (edge_cnt_q == last);

endmodule

// File: rtl/uart_rx_core.sv
// ----------------------------------------------------------------------------
// uart_rx_core
// UART receive front end: deserialises the oversampled RX_IN line into bytes
// (LSB first), checks start glitch, optional parity and stop bit, and hands
// each good byte to the system controller.
// Ports:
//   CLK       oversampling clock, PRESCALE cycles per bit
//   RST       asynchronous active-low reset
//   RX_IN     serial line, idle high
//   PRESCALE  oversampling ratio (8/16/32; anything else runs as 8)
//   PAR_EN    frame carries a parity bit
//   PAR_TYP   0 = even parity, 1 = odd parity
//   P_DATA    last good byte, held until the next good frame
//   DATA_VLD  one-cycle strobe, P_DATA updated
//   PAR_ERR   one-cycle strobe, parity mismatch
//   STP_ERR   one-cycle strobe, stop bit sampled low
// Build option:
//   UART_RX_SYNC_EN  defined: RX_IN passes a two-flop synchroniser (reset to 1),
//                    adding 2 cycles to every latency. Undefined: RX_IN must
//                    already be synchronous to CLK.
// ----------------------------------------------------------------------------
module uart_rx_core
    import uart_rx_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VLD,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic rx;

`ifdef UART_RX_SYNC_EN
    logic [1:0] rx_sync_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= {rx_sync_q[0], RX_IN};
        end
    end

    assign rx = rx_sync_q[1];
`else
    assign rx = RX_IN;
`endif

    rx_state_e             state_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] prescale_sel;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_bad_q;
    logic                  stop_bad_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  data_vld_q;
    logic                  par_err_q;
    logic                  stp_err_q;

    logic [PRESCALE_W-1:0] edge_cnt;
    logic                  sampled_bit;
    logic                  sample_done;
    logic                  bit_done;
    logic                  frame_start;
    logic                  stop_last;
    logic                  exp_parity;

    assign prescale_sel = PRESCALE_W'(legal_prescale(32'(PRESCALE)));
    assign frame_start  = (state_q == IDLE || state_q == CHECK) && !rx;
    // CHECK occupies the final oversample of the stop bit, so a frame spans
    // exactly (bits * P) cycles and back-to-back frames do not drift.
    assign stop_last    = (edge_cnt == prescale_q - PRESCALE_W'(2));
    assign exp_parity   = par_typ_q ? ~(^shift_q) : (^shift_q);

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .enable      (state_q != IDLE),
        .rx          (rx),
        .prescale    (prescale_q),
        .edge_cnt    (edge_cnt),
        .sampled_bit (sampled_bit),
        .sample_done (sample_done),
        .bit_done    (bit_done)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            prescale_q <= PRESCALE_W'(PRESCALE_DEFAULT);
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
            p_data_q   <= '0;
            data_vld_q <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
        end else begin
            data_vld_q <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (!rx) state_q <= START;
                end
                START: begin
                    if (sample_done && sampled_bit) begin
                        state_q <= IDLE;  // start bit did not hold: glitch
                    end else if (bit_done) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (sample_done) begin
                        shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    end
                    if (bit_done) begin
                        if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (sample_done) par_bad_q <= (sampled_bit != exp_parity);
                    if (bit_done) state_q <= STOP;
                end
                STOP: begin
                    if (stop_last) begin
                        stop_bad_q <= ~sampled_bit;
                        state_q    <= CHECK;
                    end
                end
                CHECK: begin
                    stp_err_q <= stop_bad_q;
                    par_err_q <= par_bad_q;
                    if (!stop_bad_q && !par_bad_q) begin
                        p_data_q   <= shift_q;
                        data_vld_q <= 1'b1;
                    end
                    state_q <= rx ? IDLE : START;
                end
                default: state_q <= IDLE;
            endcase

            if (frame_start) begin
                prescale_q <= prescale_sel;
                par_en_q   <= PAR_EN;
                par_typ_q  <= PAR_TYP;
                bit_cnt_q  <= '0;
                par_bad_q  <= 1'b0;
            end
        end
    end

    assign P_DATA   = p_data_q;
    assign DATA_VLD = data_vld_q;
    assign PAR_ERR  = par_err_q;
    assign STP_ERR  = stp_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_core
// Self-checking bench for uart_rx_core. Frames are driven bit by bit; for each
// frame a frame-level model predicts the strobe cycle, which strobes fire and
// the P_DATA value, and a cycle monitor compares the DUT against that queue.
// ----------------------------------------------------------------------------
module tb_uart_rx_core;
    import uart_rx_core_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned PW = 6;
`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic          CLK      = 1'b0;
    logic          RST      = 1'b0;
    logic          RX_IN    = 1'b1;
    logic [PW-1:0] PRESCALE = PW'(8);
    logic          PAR_EN   = 1'b0;
    logic          PAR_TYP  = 1'b0;
    logic [DW-1:0] P_DATA;
    logic          DATA_VLD;
    logic          PAR_ERR;
    logic          STP_ERR;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int         cyc;
        bit         vld;
        bit         perr;
        bit         serr;
        logic [7:0] pdata;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] last_good = 8'h00;

    uart_rx_core #(
        .DATA_WIDTH (DW),
        .PRESCALE_W (PW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX_IN    (RX_IN),
        .PRESCALE (PRESCALE),
        .PAR_EN   (PAR_EN),
        .PAR_TYP  (PAR_TYP),
        .P_DATA   (P_DATA),
        .DATA_VLD (DATA_VLD),
        .PAR_ERR  (PAR_ERR),
        .STP_ERR  (STP_ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int eff_p(input int p);
        return (p == 8 || p == 16 || p == 32) ? p : 8;
    endfunction

    // Called at #1 after a posedge; returns at #1 after a posedge.
    task automatic hold(input logic v, input int n);
        RX_IN = v;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input int p_in, input bit pe,
                              input bit pt, input bit flip, input bit stop_val,
                              input int gap_bits);
        int   p;
        int   ones;
        logic par_bit;
        exp_t e;
        p        = eff_p(p_in);
        PRESCALE = PW'(p_in);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        // Parity bit that makes the total count of ones even (pt=0) or odd (pt=1).
        par_bit  = logic'((($countones(data) + int'(pt)) % 2) != 0) ^ flip;
        ones     = $countones(data) + int'(par_bit);
        e.perr   = pe && ((ones % 2) != int'(pt));
        e.serr   = !stop_val;
        e.vld    = !e.perr && !e.serr;
        if (e.vld) last_good = data;
        e.pdata  = last_good;
        e.cyc    = cyc + 1 + SYNC_LAT + (pe ? 11 : 10) * p;
        exp_q.push_back(e);
        hold(1'b0, p);
        for (int i = 0; i < 8; i++) hold(data[i], p);
        if (pe) hold(par_bit, p);
        hold(stop_val, p);
        if (gap_bits > 0) hold(1'b1, gap_bits * p);
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_e = exp_q.pop_front();
                check_val("data_vld", 32'(DATA_VLD), 32'(mon_e.vld));
                check_val("par_err", 32'(PAR_ERR), 32'(mon_e.perr));
                check_val("stp_err", 32'(STP_ERR), 32'(mon_e.serr));
                check_val("p_data", 32'(P_DATA), 32'(mon_e.pdata));
            end else if (DATA_VLD || PAR_ERR || STP_ERR) begin
                check_val("spurious_strobe", 32'({DATA_VLD, PAR_ERR, STP_ERR}), 32'(0));
            end
        end
    end

    initial begin
        logic [7:0] dd;
        int         p_sel;
        int         p_in;
        bit         stop_val;
        int         gap;

        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_val("rst_p_data", 32'(P_DATA), 32'(0));
        check_val("rst_data_vld", 32'(DATA_VLD), 32'(0));
        check_val("rst_par_err", 32'(PAR_ERR), 32'(0));
        check_val("rst_stp_err", 32'(STP_ERR), 32'(0));
        RST = 1'b1;
        hold(1'b1, 20);

        // Plain frame, P=8, no parity.
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 2);

        // Two even-parity frames at P=16 with no idle gap between them.
        send_frame(CMD_AA, 16, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        send_frame(CMD_BB, 16, 1'b1, 1'b0, 1'b0, 1'b1, 2);

        // Odd parity with the wrong parity bit.
        send_frame(8'h0F, 8, 1'b1, 1'b1, 1'b1, 1'b1, 2);

        // Stop bit low, then a good frame.
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 2);

        // Short low glitch at P=32, then a real frame.
        PRESCALE = PW'(32);
        PAR_EN   = 1'b0;
        hold(1'b0, 3);
        hold(1'b1, 64);
        send_frame(CMD_CC, 32, 1'b0, 1'b0, 1'b0, 1'b1, 2);

        // Illegal ratio runs at 8 cycles per bit.
        send_frame(8'h96, 12, 1'b0, 1'b0, 1'b0, 1'b1, 2);

        // Reset in the middle of the data bits.
        dd       = CMD_DD;
        PRESCALE = PW'(16);
        PAR_EN   = 1'b0;
        hold(1'b0, 16);
        for (int i = 0; i < 3; i++) hold(dd[i], 16);
        RST = 1'b0;
        #1;
        check_val("midrst_p_data", 32'(P_DATA), 32'(0));
        check_val("midrst_data_vld", 32'(DATA_VLD), 32'(0));
        check_val("midrst_par_err", 32'(PAR_ERR), 32'(0));
        check_val("midrst_stp_err", 32'(STP_ERR), 32'(0));
        exp_q.delete();
        last_good = 8'h00;
        RX_IN     = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        hold(1'b1, 16);
        send_frame(8'h11, 16, 1'b0, 1'b0, 1'b0, 1'b1, 2);

        // Random frames: mixed ratios, parity modes, corruptions and gaps.
        for (int k = 0; k < 40; k++) begin
            p_sel = int'($urandom_range(0, 9));
            case (p_sel)
                0, 1, 2: p_in = 8;
                3, 4, 5: p_in = 16;
                6, 7, 8: p_in = 32;
                default: p_in = int'($urandom_range(0, 63));
            endcase
            stop_val = ($urandom_range(0, 7) != 0);
            gap      = stop_val ? int'($urandom_range(0, 2)) : 1 + int'($urandom_range(0, 1));
            send_frame(8'($urandom), p_in, 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 7) == 0), stop_val, gap);
        end

        hold(1'b1, 400);
        check_val("pending_events", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
